// File: rtl/wb_mem_arbiter.sv
// Two-master round-robin Wishbone arbiter for a shared memory port.
// Single-beat transactions, one IDLE cycle between grants, hang timeout.
module wb_mem_arbiter #(
  parameter int ADR_W   = 16,
  parameter int TIMEOUT = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [ADR_W-1:2] i_wbm0_adr,
  input  logic [31:0]      i_wbm0_dat,
  input  logic [3:0]       i_wbm0_sel,
  input  logic             i_wbm0_we,
  input  logic             i_wbm0_cyc,
  input  logic             i_wbm0_stb,
  output logic [31:0]      o_wbm0_rdt,
  output logic             o_wbm0_ack,
  output logic             o_wbm0_err,
  input  logic [ADR_W-1:2] i_wbm1_adr,
  input  logic [31:0]      i_wbm1_dat,
  input  logic [3:0]       i_wbm1_sel,
  input  logic             i_wbm1_we,
  input  logic             i_wbm1_cyc,
  input  logic             i_wbm1_stb,
  output logic [31:0]      o_wbm1_rdt,
  output logic             o_wbm1_ack,
  output logic             o_wbm1_err,
  output logic [ADR_W-1:2] o_wbs_adr,
  output logic [31:0]      o_wbs_dat,
  output logic [3:0]       o_wbs_sel,
  output logic             o_wbs_we,
  output logic             o_wbs_cyc,
  output logic             o_wbs_stb,
  input  logic [31:0]      i_wbs_rdt,
  input  logic             i_wbs_ack
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TLAST =
    TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic TO_EN = (TIMEOUT > 0);

  state_t        state;
  logic          gnt;
  logic          last;
  logic [TW-1:0] tcnt;

  logic req0, req1, req_g, busy;
  logic ack_g, to_g, done;

  assign req0  = i_wbm0_cyc & i_wbm0_stb;
  assign req1  = i_wbm1_cyc & i_wbm1_stb;
  assign req_g = gnt ? req1 : req0;
  assign busy  = (state == GRANT);
  assign ack_g = busy & req_g & i_wbs_ack;
  assign to_g  = TO_EN & busy & req_g & ~i_wbs_ack
               & (tcnt == TLAST);
  assign done  = ~req_g | ack_g | to_g;

  // Route the granted master onto the slave port and responses back
  always_comb begin
    o_wbs_adr  = gnt ? i_wbm1_adr : i_wbm0_adr;
    o_wbs_dat  = gnt ? i_wbm1_dat : i_wbm0_dat;
    o_wbs_sel  = gnt ? i_wbm1_sel : i_wbm0_sel;
    o_wbs_we   = busy & (gnt ? i_wbm1_we : i_wbm0_we);
    o_wbs_cyc  = busy & req_g;
    o_wbs_stb  = busy & req_g;
    o_wbm0_ack = ack_g & ~gnt;
    o_wbm1_ack = ack_g & gnt;
    o_wbm0_err = to_g & ~gnt;
    o_wbm1_err = to_g & gnt;
    o_wbm0_rdt = i_wbs_rdt;
    o_wbm1_rdt = i_wbs_rdt;
  end

  // Grant FSM: pick a master in IDLE, release on ack, abort or timeout
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      gnt   <= 1'b0;
      last  <= 1'b1;
      tcnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req0 | req1) begin
            state <= GRANT;
            tcnt  <= '0;
            gnt   <= (req0 & req1) ? ~last : req1;
          end
        end
        GRANT: begin
          if (done) begin
            state <= IDLE;
            last  <= gnt;
          end else if (TO_EN) begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/wb_mem_arbiter.md
Name: wb_mem_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter that shares a single on-chip memory port (e.g. core data bus and a DMA/debug master).
- Grants one classic single-beat transaction at a time with round-robin fairness.
- Routes ack/data back to the granted master only, and aborts hung transactions with a timeout error.
- Sits between the masters and the memory wrapper, whose ack is registered one cycle after cyc&stb.

Parameters:
ADR_W, 16, byte-address width; address ports are [ADR_W-1:2]
TIMEOUT, 16, cycles in GRANT without slave ack before an error is returned; 0 disables the timeout

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_wbm0_adr  in  ADR_W-2  master 0 word address
i_wbm0_dat  in  32  master 0 write data
i_wbm0_sel  in  4  master 0 byte selects
i_wbm0_we  in  1  master 0 write enable
i_wbm0_cyc  in  1  master 0 cycle
i_wbm0_stb  in  1  master 0 strobe
o_wbm0_rdt  out  32  master 0 read data
o_wbm0_ack  out  1  master 0 ack
o_wbm0_err  out  1  master 0 timeout error
i_wbm1_*, o_wbm1_*  same set for master 1
o_wbs_adr  out  ADR_W-2  slave address
o_wbs_dat  out  32  slave write data
o_wbs_sel  out  4  slave byte selects
o_wbs_we  out  1  slave write enable
o_wbs_cyc  out  1  slave cycle
o_wbs_stb  out  1  slave strobe
i_wbs_rdt  in  32  slave read data
i_wbs_ack  in  1  slave ack

Behaviour:
- Request: reqN = i_wbmN_cyc & i_wbmN_stb. Masters must hold all request signals stable until ack or err.
- Registered state: state (IDLE/GRANT), gnt (0/1), last (last master served), tcnt (timeout counter, width $clog2(TIMEOUT+1), minimum 1).
- Reset (async, i_rst_n=0): state=IDLE, gnt=0, last=1 (master 0 wins the first tie), tcnt=0.
- Outputs during reset: all o_wbs_cyc/stb/we, o_wbmN_ack and o_wbmN_err are 0.
- IDLE:
  - o_wbs_cyc=o_wbs_stb=0; slave ack is ignored and never forwarded.
  - With exactly one request, gnt<=requester.
  - With both requesting, gnt<=!last.
  - On any request, state<=GRANT and tcnt<=0.
- GRANT:
  - o_wbs_adr/dat/sel/we are muxed combinationally from master gnt.
  - o_wbs_cyc=o_wbs_stb=req[gnt].
  - o_wbmN_ack=i_wbs_ack & (gnt==N) & req[gnt].
  - o_wbs_rdt: i_wbs_rdt fans out to both masters unconditionally; data is valid only with ack.
- Leaving GRANT:
  - On forwarded ack: state<=IDLE, last<=gnt.
  - If req[gnt] drops before ack (abort): state<=IDLE, last<=gnt, no ack/err issued. A late slave ack arriving in IDLE is dropped.
  - Timeout (TIMEOUT>0): tcnt increments every GRANT cycle without ack. When tcnt==TIMEOUT-1 and no ack, o_wbmN_err=1 for the granted master for that cycle only, then state<=IDLE, last<=gnt.
  - Ack and timeout in the same cycle: ack wins and err stays 0.
- Latency: request seen in IDLE at cycle 0; o_wbs_stb at cycle 1; ack to master at cycle 2 with a 1-cycle slave.
- One mandatory IDLE cycle separates transactions, guaranteeing the slave sees stb low after each ack.
- Fairness: with continuous requests from both masters, grants strictly alternate.
- ack and err are never asserted to the non-granted master. No two acks are asserted in the same cycle.
- Reset mid-transaction: returns to IDLE immediately. The in-flight slave access may complete at the slave but is not acknowledged.

Test Plan:
- Single master 0 read of address 0x10, slave ack after 1 cycle -> o_wbs_stb high in cycle 1; o_wbm0_ack in cycle 2 with o_wbm0_rdt = slave data; o_wbm1_ack stays 0.
- Both masters request writes continuously from reset (m0 data 0xAAAA_0000, m1 data 0x5555_0000) -> slave sees m0, m1, m0, m1 in that order, each transaction followed by one IDLE cycle.
- Master 1 requests alone, then both request -> master 0 is granted next (last=1), then master 1.
- Slave never acks, TIMEOUT=16 -> o_wbm0_err pulses exactly in the 16th GRANT cycle; arbiter returns to IDLE; master 1 can be served afterwards.
- Master 0 drops cyc after 1 GRANT cycle, slave acks one cycle later -> no ack/err to either master; the next request is granted normally.
- Assert i_rst_n low during GRANT -> o_wbs_cyc drops asynchronously; after release, the first simultaneous request goes to master 0.
